// File: rtl/alu_seq_if.sv
// Request/response bundle for the sequential ALU: the requester drives the operation,
// the ALU returns the registered result, flags and handshake status.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       Sel;
  logic [WIDTH-1:0] Res;
  logic             zero_flag;
  logic             div_zero;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Sel,
    input  Res, zero_flag, div_zero, busy, done
  );

  modport slave (
    input  start, A, B, Sel,
    output Res, zero_flag, div_zero, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: most operations complete in the accepting cycle, while MUL (shift-add)
// and DIV (restoring) iterate one bit per clock for WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic     clk,
  input  logic     reset,
  alu_seq_if.slave bus
);
  localparam int         SH_W   = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] op_a, op_a_n;
  logic [WIDTH-1:0] op_b, op_b_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic             b_zero, b_zero_n;
  logic [WIDTH-1:0] res_q, res_n;
  logic             zero_q, zero_n;
  logic             divz_q, divz_n;
  logic             done_q, done_n;

  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] div_res;
  logic             last;

  // Single-cycle operations; MUL/DIV codes fall through to zero here and are handled by the FSM.
  always_comb begin
    alu_res = '0;
    case (bus.Sel)
      4'b0001: alu_res = bus.A + bus.B;
      4'b0010: alu_res = bus.A - bus.B;
      4'b0101: alu_res = bus.A & bus.B;
      4'b0110: alu_res = bus.A | bus.B;
      4'b0111: alu_res = ~(bus.A | bus.B);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b1001: alu_res = bus.A ^ bus.B;
      4'b1010: alu_res = bus.A << bus.B[SH_W-1:0];
      4'b1011: alu_res = bus.A >> bus.B[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  // MUL keeps multiplicand in op_a, multiplier in op_b; DIV shifts the dividend out of op_a
  // while quotient bits shift in, with the remainder in acc (it always fits in WIDTH bits).
  assign mul_sum  = acc + (op_b[0] ? op_a : '0);
  assign rem_sh   = {acc, op_a[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, op_b};
  assign quo_n    = {op_a[WIDTH-2:0], ~rem_diff[WIDTH]};
  assign div_res  = b_zero ? '1 : quo_n;
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      acc    <= '0;
      b_zero <= 1'b0;
      res_q  <= '0;
      zero_q <= 1'b1;
      divz_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      acc    <= acc_n;
      b_zero <= b_zero_n;
      res_q  <= res_n;
      zero_q <= zero_n;
      divz_q <= divz_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_a_n   = op_a;
    op_b_n   = op_b;
    acc_n    = acc;
    b_zero_n = b_zero;
    res_n    = res_q;
    zero_n   = zero_q;
    divz_n   = divz_q;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.Sel == OP_MUL || bus.Sel == OP_DIV) begin
            op_a_n   = bus.A;
            op_b_n   = bus.B;
            acc_n    = '0;
            cnt_n    = '0;
            b_zero_n = (bus.B == '0);
            state_n  = (bus.Sel == OP_MUL) ? MUL : DIV;
          end else begin
            res_n  = alu_res;
            zero_n = (alu_res == '0);
            divz_n = 1'b0;
            done_n = 1'b1;
          end
        end
      end
      MUL: begin
        acc_n  = mul_sum;
        op_a_n = op_a << 1;
        op_b_n = op_b >> 1;
        cnt_n  = cnt + 1'b1;
        if (last) begin
          res_n   = mul_sum;
          zero_n  = (mul_sum == '0);
          divz_n  = 1'b0;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      DIV: begin
        acc_n  = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
        op_a_n = quo_n;
        cnt_n  = cnt + 1'b1;
        if (last) begin
          res_n   = div_res;
          zero_n  = (div_res == '0);
          divz_n  = b_zero;
          done_n  = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Res       = res_q;
  assign bus.zero_flag = zero_q;
  assign bus.div_zero  = divz_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_alu_seq;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [WIDTH-1:0] exp_res;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour expressed directly with arithmetic on the operands.
  function automatic void refModel(input logic [3:0] sel, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] r,
                                   output logic dz, output int lat);
    longint unsigned prod;
    dz  = 1'b0;
    lat = (sel == 4'd3 || sel == 4'd4) ? WIDTH : 0;
    case (sel)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  begin prod = longint'(a) * longint'(b); r = prod[WIDTH-1:0]; end
      4'd4:  if (b == 0) begin r = '1; dz = 1'b1; end else r = a / b;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = ~(a | b);
      4'd8:  r = (a < b) ? 1 : 0;
      4'd9:  r = a ^ b;
      4'd10: r = a << (b % WIDTH);
      4'd11: r = a >> (b % WIDTH);
      default: r = '0;
    endcase
  endfunction

  // Presents one request at the current negedge and follows it to completion.
  task automatic applyStimulus(input logic [3:0] sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input bit noisy, input bit hold);
    logic [WIDTH-1:0] r;
    logic             dz;
    int               lat;
    int               cycles;
    refModel(sel, a, b, r, dz, lat);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Sel   = sel;
    @(negedge clk);
    cycles = 0;
    while (!bus.done && cycles < 100) begin
      checkOutput("busy_during_op", bus.busy, 1);
      checkOutput("res_hold", bus.Res, exp_res);
      if (noisy) begin
        bus.start = 1'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.Sel   = 4'($urandom);
      end else if (!hold) begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    exp_res = r;
    checkOutput("latency", cycles, lat);
    checkOutput("res", bus.Res, r);
    checkOutput("zero_flag", bus.zero_flag, (r == 0));
    checkOutput("div_zero", bus.div_zero, dz);
    checkOutput("busy_at_done", bus.busy, 0);
    if (!hold) begin
      bus.start = 1'b0;
      @(negedge clk);
      checkOutput("done_one_cycle", bus.done, 0);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("done_while_busy", bus.done & bus.busy, 0);
  end

  initial begin
    logic [3:0]       sel;
    logic [WIDTH-1:0] a, b;
    exp_res   = '0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Sel   = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_res", bus.Res, 0);
    checkOutput("rst_zero", bus.zero_flag, 1);
    checkOutput("rst_divz", bus.div_zero, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    reset = 1'b0;

    applyStimulus(4'b0001, 32'hFFFF_FFFF, 32'h1, 0, 0);
    applyStimulus(4'b0011, 32'h0001_0000, 32'h0001_0003, 1, 0);
    applyStimulus(4'b0100, 32'd100, 32'd7, 1, 0);
    applyStimulus(4'b0100, 32'd5, 32'd0, 0, 0);
    applyStimulus(4'b1010, 32'h1, 32'h25, 0, 0);
    applyStimulus(4'b1011, 32'h8000_0000, 32'd31, 0, 0);
    applyStimulus(4'b1000, 32'd3, 32'hFFFF_FFFF, 0, 0);
    applyStimulus(4'b1111, 32'h1234, 32'h5678, 0, 0);

    // Reset partway through a divide must abort it silently.
    bus.start = 1'b1;
    bus.Sel   = 4'b0100;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_res", bus.Res, 0);
    checkOutput("midrst_zero", bus.zero_flag, 1);
    checkOutput("midrst_divz", bus.div_zero, 0);
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_done", bus.done, 0);
    bus.start = 1'b1;
    bus.Sel   = 4'b0001;
    bus.A     = 32'd5;
    bus.B     = 32'd6;
    @(negedge clk);
    checkOutput("start_in_reset", bus.done, 0);
    reset   = 1'b0;
    exp_res = '0;
    applyStimulus(4'b1001, 32'hF0F0_1234, 32'h0FF0_4321, 0, 0);
    repeat (40) begin
      @(negedge clk);
      checkOutput("no_stale_done", bus.done, 0);
    end

    // Start held high across alternating MUL and ADD requests.
    for (int i = 0; i < 8; i++) begin
      sel = (i % 2 == 0) ? 4'b0011 : 4'b0001;
      applyStimulus(sel, $urandom, $urandom, 0, (i != 7));
    end

    for (int i = 0; i < 40; i++) begin
      sel = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = WIDTH'($urandom_range(0, 3));
        1:       a = WIDTH'($urandom_range(0, 255));
        default: ;
      endcase
      applyStimulus(sel, a, b, 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits (legal range 8..64).
REQ-002 The block SHALL have parameter CNT_W, default 6, giving the iteration counter width (must satisfy 2^CNT_W > WIDTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 A  input  WIDTH  operand A, sampled on accepted start.
REQ-007 B  input  WIDTH  operand B, sampled on accepted start.
REQ-008 Sel  input  4  operation select, sampled on accepted start.
REQ-009 Res  output  WIDTH  registered result, held until next completion.
REQ-010 zero_flag  output  1  registered; 1 when the Res value loaded at the same completion is all zeros.
REQ-011 div_zero  output  1  registered; 1 when the completed operation was DIV with B=0.
REQ-012 busy  output  1  1 while an accepted operation is in progress.
REQ-013 done  output  1  one-cycle pulse marking a completion.

Function
REQ-014 Sel encoding SHALL be: 0000 zero; 0001 A+B; 0010 A-B; 0011 MUL (low WIDTH bits of unsigned A*B); 0100 DIV (unsigned A/B quotient); 0101 A&B; 0110 A|B; 0111 ~(A|B); 1000 unsigned SLT (1 if A<B, else 0); 1001 A^B; 1010 A<<B[log2(WIDTH)-1:0]; 1011 A>>B[log2(WIDTH)-1:0] (logical); 1100-1111 result 0.
REQ-015 Add and subtract SHALL wrap modulo 2^WIDTH; carry/borrow is discarded.
REQ-016 FSM states SHALL be IDLE, MUL, and DIV; only IDLE accepts start.
REQ-017 A single-cycle op (any Sel other than 0011/0100) accepted at edge k SHALL load Res, zero_flag, div_zero=0, and done=1 at edge k; busy SHALL stay 0.
REQ-018 MUL accepted at edge k SHALL latch operands, set busy=1, and enter MUL.
REQ-019 MUL SHALL run a radix-2 shift-add, one iteration per edge, for WIDTH iterations.
REQ-020 MUL SHALL load Res and zero_flag, pulse done, clear busy, and return to IDLE at edge k+WIDTH.
REQ-021 DIV accepted at edge k SHALL run a restoring divide, one quotient bit per edge, with the same timing as MUL: done at edge k+WIDTH.
REQ-022 DIV with B=0 SHALL still take WIDTH cycles, then produce Res=all ones, div_zero=1, zero_flag=0.
REQ-023 start while busy=1 SHALL be ignored: no latch, no queue, no effect on the running operation.
REQ-024 start may be held high; a new request SHALL be accepted on the first edge with busy=0, including the edge immediately after a done.
REQ-025 done SHALL be high for exactly one cycle per accepted operation and SHALL never be high while busy=1.
REQ-026 Res, zero_flag, and div_zero SHALL change only at a completion edge; between completions they SHALL hold their values.
REQ-027 Changes on A, B, or Sel after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-028 reset=1 SHALL immediately force: state IDLE, Res=0, zero_flag=1, div_zero=0, busy=0, done=0, counter=0, working registers=0.
REQ-029 reset asserted mid-MUL or mid-DIV SHALL abort the operation with no done pulse; after release the block SHALL accept a new start on the first edge.
REQ-030 start coincident with reset SHALL be ignored.

Verification
REQ-031 Reset, then WIDTH=32, Sel=0001, A=0xFFFFFFFF, B=1, one-cycle start -> done 1 cycle, Res=0, zero_flag=1, busy never 1.
REQ-032 Sel=0011, A=0x00010000, B=0x00010003 -> busy for 32 cycles, then done, Res=0x00030000; start pulses during busy are ignored and Res is unchanged until done.
REQ-033 Sel=0100, A=100, B=7 -> done after 32 cycles, Res=14; then A=5, B=0 -> Res=0xFFFFFFFF, div_zero=1, zero_flag=0.
REQ-034 Sel=1010, A=1, B=0x25 -> Res=0x20; Sel=1011, A=0x80000000, B=31 -> Res=1; Sel=1000, A=3, B=0xFFFFFFFF -> Res=1.
REQ-035 Start DIV, assert reset at cycle 10 -> all outputs are at reset values immediately and no done pulse occurs; a single-cycle Sel=1001 (A^B) start after release completes normally.
REQ-036 Hold start high with alternating MUL and ADD requests -> back-to-back acceptance, exactly one done per operation, and correct results in order.
